cpu_pipestage: RTL and testbench
================================

CPU_PIPESTAGE -- requirements
Module: cpu_pipestage

Interface
REQ-001 SHALL have parameter PIPE_WIDTH, default 32, payload width in bits (>=1).
REQ-002 SHALL have parameter SKID_EN, default 1; 1 = registered-ready two-entry skid mode, 0 = single-entry mode with combinational ready.
REQ-003 SHALL have parameter NOP_VALUE, default {PIPE_WIDTH{1'b0}}, the payload driven during bubbles.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, stall-counter width (>=1).
REQ-005 clk  input  1  clock; all state changes on posedge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  upstream payload valid.
REQ-008 in_ready  output  1  stage can accept in_data this cycle.
REQ-009 in_data  input  PIPE_WIDTH  upstream payload.
REQ-010 out_valid  output  1  out_data holds a live entry.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 out_data  output  PIPE_WIDTH  head payload; NOP_VALUE when out_valid=0.
REQ-013 flush  input  1  synchronous kill of all held entries.
REQ-014 clr_cnt  input  1  synchronous clear of stall_cnt.
REQ-015 stall_cnt  output  CNT_WIDTH  saturating count of backpressure cycles.

Function
REQ-016 Push = in_valid && in_ready; pop = out_valid && out_ready; both evaluated at the same posedge.
REQ-017 SHALL hold an occupancy state: EMPTY, ONE (main entry valid), TWO (main + skid valid; SKID_EN=1 only).
REQ-018 out_valid SHALL be 1 in ONE and TWO; out_data SHALL be the main register, driven from a flop (no combinational path from in_data).
REQ-019 SKID_EN=1: in_ready SHALL be a registered signal, 1 in EMPTY and ONE, 0 in TWO; no combinational path from out_ready to in_ready.
REQ-020 SKID_EN=0: in_ready SHALL equal !out_valid || out_ready (combinational); TWO SHALL be unreachable.
REQ-021 EMPTY: push -> ONE, main <= in_data; else stay.
REQ-022 ONE: push && pop -> ONE, main <= in_data; pop only -> EMPTY, main <= NOP_VALUE; push only -> TWO (SKID_EN=1), skid <= in_data; neither -> stay.
REQ-023 TWO: pop -> ONE, main <= skid; no push possible; otherwise stay with both entries unchanged.
REQ-024 Payload order SHALL be preserved; no entry SHALL be dropped or duplicated absent flush.
REQ-025 Latency SHALL be one cycle: payload pushed at edge N appears on out_data after edge N when the stage was EMPTY.
REQ-026 flush SHALL have priority over push and pop: next state EMPTY, main <= NOP_VALUE, skid invalidated, in_ready <= 1; a push coincident with flush is discarded; a pop coincident with flush counts as a completed transfer downstream.
REQ-027 stall_cnt SHALL increment by 1 each cycle out_valid && !out_ready and flush=0, saturating at all-ones (no wrap).
REQ-028 clr_cnt SHALL set stall_cnt to 0 and take priority over increment; flush SHALL NOT affect stall_cnt.
REQ-029 Skid register contents SHALL be don't-care when not valid but SHALL never be presented on out_data.

Reset
REQ-030 On rst_n low, asynchronously: state EMPTY, out_valid=0, out_data=NOP_VALUE, stall_cnt=0, skid invalid.
REQ-031 in_ready SHALL be 0 while rst_n is low and SHALL be 1 from the first posedge after rst_n deasserts (SKID_EN=1); SKID_EN=0 follows REQ-020.
REQ-032 Reset asserted mid-operation SHALL discard all entries with no partial transfer.

Verification
REQ-033 Reset, then in_valid=1, in_data=0xA5A5A5A5, out_ready=1 for one cycle -> next cycle out_valid=1, out_data=0xA5A5A5A5; following cycle out_valid=0, out_data=0.
REQ-034 SKID_EN=1, out_ready=0, push 0x1 then 0x2 -> in_ready=0 after second push; then out_ready=1 -> out_data 0x1 then 0x2, in_ready returns 1, stall_cnt=2.
REQ-035 Streaming 0..99 with out_ready toggling pseudo-randomly, both SKID_EN values -> output sequence exactly 0..99, no gaps or repeats.
REQ-036 State TWO plus flush with in_valid=1 -> next cycle out_valid=0, out_data=NOP_VALUE, in_ready=1, no flushed or coincident payload ever emitted.
REQ-037 CNT_WIDTH=4, out_valid held with out_ready=0 for 20 cycles -> stall_cnt saturates at 15; clr_cnt pulse -> 0 next cycle.
REQ-038 rst_n pulsed low asynchronously while in TWO -> outputs immediately at reset values; no entry emitted after release.

Source files
------------

// File: rtl/cpu_pipestage.sv
// cpu_pipestage: one pipeline stage with valid/ready handshaking.
// SKID_EN=1 gives a two-entry skid buffer with a registered in_ready;
// SKID_EN=0 gives a single entry with a combinational in_ready.
// A saturating counter records the cycles spent under backpressure.
module cpu_pipestage #(
    parameter int                    PIPE_WIDTH = 32,
    parameter int                    SKID_EN    = 1,
    parameter logic [PIPE_WIDTH-1:0] NOP_VALUE  = {PIPE_WIDTH{1'b0}},
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PIPE_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PIPE_WIDTH-1:0] out_data,
    input  logic                  flush,
    input  logic                  clr_cnt,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occState_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    occState_t              state_q, state_d;
    logic [PIPE_WIDTH-1:0]  mainData_q, mainData_d;
    logic [PIPE_WIDTH-1:0]  skidData_q, skidData_d;
    logic                   inReady_q, inReady_d;
    logic [CNT_WIDTH-1:0]   stallCnt_q, stallCnt_d;
    logic                   push;
    logic                   pop;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // State and data registers; reset clears everything, including the ready flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            mainData_q <= NOP_VALUE;
            skidData_q <= NOP_VALUE;
            inReady_q  <= 1'b0;
            stallCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mainData_q <= mainData_d;
            skidData_q <= skidData_d;
            inReady_q  <= inReady_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    // Next occupancy and payload movement; flush overrides any handshake.
    always_comb begin
        state_d    = state_q;
        mainData_d = mainData_q;
        skidData_d = skidData_q;
        if (flush) begin
            state_d    = EMPTY;
            mainData_d = NOP_VALUE;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d    = ONE;
                        mainData_d = in_data;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        mainData_d = in_data;
                    end else if (pop) begin
                        state_d    = EMPTY;
                        mainData_d = NOP_VALUE;
                    end else if (push && (SKID_EN != 0)) begin
                        state_d    = TWO;
                        skidData_d = in_data;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d    = ONE;
                        mainData_d = skidData_q;
                    end
                end
                default: begin
                    state_d    = EMPTY;
                    mainData_d = NOP_VALUE;
                end
            endcase
        end
        // The registered ready only closes when the skid entry will be occupied.
        inReady_d = (state_d != TWO);
    end

    // Backpressure counter: clear wins, then count stalled cycles, saturating.
    always_comb begin
        stallCnt_d = stallCnt_q;
        if (clr_cnt) begin
            stallCnt_d = '0;
        end else if (out_valid && !out_ready && !flush && (stallCnt_q != CNT_MAX)) begin
            stallCnt_d = stallCnt_q + 1'b1;
        end
    end

    // Outputs come straight from flops, except the single-entry ready.
    always_comb begin
        out_valid = (state_q != EMPTY);
        out_data  = mainData_q;
        stall_cnt = stallCnt_q;
        if (SKID_EN != 0) begin
            in_ready = inReady_q;
        end else begin
            in_ready = !out_valid || out_ready;
        end
    end

endmodule

// File: tb/tb_cpu_pipestage.sv
// tb_cpu_pipestage: directed bench for cpu_pipestage, covering a skid-mode
// instance (defaults) and a single-entry instance with a 4-bit counter.
module tb_cpu_pipestage;

    logic        clk;
    logic        rst_n;

    logic        inValidA, inReadyA, outValidA, outReadyA, flushA, clrCntA;
    logic [31:0] inDataA, outDataA;
    logic [15:0] stallCntA;

    logic        inValidB, inReadyB, outValidB, outReadyB, flushB, clrCntB;
    logic [31:0] inDataB, outDataB;
    logic [3:0]  stallCntB;

    int checks = 0;
    int errors = 0;

    cpu_pipestage dutA (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValidA),
        .in_ready  (inReadyA),
        .in_data   (inDataA),
        .out_valid (outValidA),
        .out_ready (outReadyA),
        .out_data  (outDataA),
        .flush     (flushA),
        .clr_cnt   (clrCntA),
        .stall_cnt (stallCntA)
    );

    cpu_pipestage #(.PIPE_WIDTH(32), .SKID_EN(0), .CNT_WIDTH(4)) dutB (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValidB),
        .in_ready  (inReadyB),
        .in_data   (inDataB),
        .out_valid (outValidB),
        .out_ready (outReadyB),
        .out_data  (outDataB),
        .flush     (flushB),
        .clr_cnt   (clrCntB),
        .stall_cnt (stallCntB)
    );

    // Free-running clock, posedges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive dutA inputs, then advance one clock edge and settle past it.
    task automatic applyStimulus(input logic valid, input logic [31:0] data,
                                 input logic ready, input logic fl, input logic clr);
        inValidA  = valid;
        inDataA   = data;
        outReadyA = ready;
        flushA    = fl;
        clrCntA   = clr;
        @(posedge clk);
        #1;
    endtask

    int nextA, nextB, rxA, rxB, cycles;
    logic pushA, popA, pushB, popB;

    initial begin
        rst_n = 1'b0;
        inValidA = 0; inDataA = 0; outReadyA = 0; flushA = 0; clrCntA = 0;
        inValidB = 0; inDataB = 0; outReadyB = 0; flushB = 0; clrCntB = 0;

        // Reset values while rst_n is held low.
        #3;
        checkOutput("rst_in_ready", inReadyA, 0);
        checkOutput("rst_out_valid", outValidA, 0);
        checkOutput("rst_out_data", outDataA, 0);
        checkOutput("rst_stall_cnt", stallCntA, 0);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_rst_in_ready", inReadyA, 1);

        // Single transfer: one-cycle latency, then bubble.
        applyStimulus(1, 32'hA5A5A5A5, 1, 0, 0);
        checkOutput("lat_out_valid", outValidA, 1);
        checkOutput("lat_out_data", outDataA, 32'hA5A5A5A5);
        applyStimulus(0, 32'h0, 1, 0, 0);
        checkOutput("bubble_out_valid", outValidA, 0);
        checkOutput("bubble_out_data", outDataA, 0);

        // Fill skid buffer under backpressure.
        applyStimulus(1, 32'h1, 0, 0, 0);
        checkOutput("skid1_out_data", outDataA, 32'h1);
        checkOutput("skid1_in_ready", inReadyA, 1);
        applyStimulus(1, 32'h2, 0, 0, 0);
        checkOutput("skid2_in_ready", inReadyA, 0);
        checkOutput("skid2_out_data", outDataA, 32'h1);
        checkOutput("skid2_stall", stallCntA, 1);
        applyStimulus(0, 32'h0, 0, 0, 0);
        checkOutput("skid_hold_stall", stallCntA, 2);
        checkOutput("skid_hold_in_ready", inReadyA, 0);
        // Drain in order.
        applyStimulus(0, 32'h0, 1, 0, 0);
        checkOutput("drain1_out_data", outDataA, 32'h2);
        checkOutput("drain1_in_ready", inReadyA, 1);
        applyStimulus(0, 32'h0, 1, 0, 0);
        checkOutput("drain2_out_valid", outValidA, 0);
        checkOutput("drain_stall", stallCntA, 2);

        // Flush from TWO with a coincident push.
        applyStimulus(1, 32'h11, 0, 0, 0);
        applyStimulus(1, 32'h22, 0, 0, 0);
        checkOutput("pre_flush_in_ready", inReadyA, 0);
        checkOutput("pre_flush_stall", stallCntA, 3);
        applyStimulus(1, 32'h33, 0, 1, 0);
        checkOutput("flush_out_valid", outValidA, 0);
        checkOutput("flush_out_data", outDataA, 0);
        checkOutput("flush_in_ready", inReadyA, 1);
        checkOutput("flush_stall", stallCntA, 3);
        applyStimulus(0, 32'h0, 1, 0, 0);
        checkOutput("post_flush_out_valid", outValidA, 0);
        applyStimulus(0, 32'h0, 1, 0, 1);
        checkOutput("clr_stall", stallCntA, 0);

        // Asynchronous reset while in TWO.
        applyStimulus(1, 32'h44, 0, 0, 0);
        applyStimulus(1, 32'h55, 0, 0, 0);
        checkOutput("pre_rst_stall", stallCntA, 1);
        inValidA = 0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_out_valid", outValidA, 0);
        checkOutput("async_rst_out_data", outDataA, 0);
        checkOutput("async_rst_in_ready", inReadyA, 0);
        checkOutput("async_rst_stall", stallCntA, 0);
        #2 rst_n = 1'b1;
        applyStimulus(0, 32'h0, 1, 0, 0);
        checkOutput("after_rst_out_valid1", outValidA, 0);
        applyStimulus(0, 32'h0, 1, 0, 0);
        checkOutput("after_rst_out_valid2", outValidA, 0);

        // Stream 0..99 through both instances with random backpressure.
        nextA = 0; nextB = 0; rxA = 0; rxB = 0; cycles = 0;
        while ((rxA < 100 || rxB < 100) && cycles < 3000) begin
            inValidA  = (nextA < 100);
            inDataA   = nextA;
            outReadyA = 1'($urandom_range(0, 1));
            inValidB  = (nextB < 100);
            inDataB   = nextB;
            outReadyB = 1'($urandom_range(0, 1));
            #1;
            pushA = inValidA && inReadyA;
            popA  = outValidA && outReadyA;
            pushB = inValidB && inReadyB;
            popB  = outValidB && outReadyB;
            if (popA) begin
                checkOutput("stream_skid_data", outDataA, rxA);
                rxA++;
            end
            if (popB) begin
                checkOutput("stream_single_data", outDataB, rxB);
                rxB++;
            end
            @(posedge clk); #1;
            if (pushA) nextA++;
            if (pushB) nextB++;
            cycles++;
        end
        checkOutput("stream_skid_count", rxA, 100);
        checkOutput("stream_single_count", rxB, 100);
        inValidA = 0; inValidB = 0; outReadyA = 1; outReadyB = 1;
        @(posedge clk); #1;
        checkOutput("stream_skid_idle", outValidA, 0);
        checkOutput("stream_single_idle", outValidB, 0);

        // Counter saturation on the 4-bit single-entry instance.
        inValidB = 1; inDataB = 32'h7; outReadyB = 0;
        @(posedge clk); #1;
        inValidB = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
        end
        checkOutput("sat_stall", stallCntB, 15);
        checkOutput("sat_out_data", outDataB, 32'h7);
        clrCntB = 1;
        @(posedge clk); #1;
        clrCntB = 0;
        checkOutput("sat_clr", stallCntB, 0);
        @(posedge clk); #1;
        checkOutput("sat_recount", stallCntB, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
